// File: rtl/decoder_scan_ctrl_if.sv
// Control/status bundle between the scan controller and the logic driving it.
// master drives start/stop/mode/dwell; slave (the controller) returns sel and flags.
interface decoder_scan_ctrl_if #(
  parameter int DWELL_W = 8
);
  logic               start;
  logic               stop;
  logic [1:0]         mode;
  logic [DWELL_W-1:0] dwell;
  logic [2:0]         sel;
  logic               sel_valid;
  logic               step;
  logic               busy;
  logic               done;

  modport master (
    output start, stop, mode, dwell,
    input  sel, sel_valid, step, busy, done
  );

  modport slave (
    input  start, stop, mode, dwell,
    output sel, sel_valid, step, busy, done
  );
endinterface

// File: rtl/decoder_scan_ctrl.sv
// Sequential select generator feeding a 3x8 decoder: steps sel through 0..7
// with a programmable dwell in UP, DOWN, PINGPONG or ONESHOT order.
module decoder_scan_ctrl #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  decoder_scan_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    MODE_UP       = 2'b00,
    MODE_DOWN     = 2'b01,
    MODE_PINGPONG = 2'b10,
    MODE_ONESHOT  = 2'b11
  } mode_e;

  localparam logic [DWELL_W-1:0] DWELL_ONE = DWELL_W'(1);

  state_e             state_q, state_d;
  mode_e              mode_l_q, mode_l_d;
  logic [DWELL_W-1:0] dwell_l_q, dwell_l_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic               dir_up_q, dir_up_d;
  logic [2:0]         sel_q, sel_d;
  logic               sel_valid_q, sel_valid_d;
  logic               step_q, step_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [2:0]         sel_adv;
  logic               dir_adv;
  logic               dwell_expired;

  // dwell_l is never 0, so dwell_l-1 cannot underflow and cnt never exceeds 2^W-2.
  assign dwell_expired = (cnt_q == (dwell_l_q - DWELL_ONE));

  // Next index for the latched mode
  always_comb begin
    sel_adv = sel_q;
    dir_adv = dir_up_q;
    unique case (mode_l_q)
      MODE_UP, MODE_ONESHOT: sel_adv = sel_q + 3'd1;
      MODE_DOWN:             sel_adv = sel_q - 3'd1;
      MODE_PINGPONG: begin
        // Direction flips as an endpoint is reached so it is shown only once.
        if (dir_up_q) begin
          sel_adv = sel_q + 3'd1;
          dir_adv = (sel_q != 3'd6);
        end else begin
          sel_adv = sel_q - 3'd1;
          dir_adv = (sel_q == 3'd1);
        end
      end
      default: sel_adv = sel_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    mode_l_d    = mode_l_q;
    dwell_l_d   = dwell_l_q;
    cnt_d       = cnt_q;
    dir_up_d    = dir_up_q;
    sel_d       = sel_q;
    sel_valid_d = 1'b0;
    step_d      = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start && !bus.stop) begin
          mode_l_d    = mode_e'(bus.mode);
          dwell_l_d   = (bus.dwell == '0) ? DWELL_ONE : bus.dwell;
          sel_d       = (mode_e'(bus.mode) == MODE_DOWN) ? 3'd7 : 3'd0;
          cnt_d       = '0;
          dir_up_d    = 1'b1;
          state_d     = ST_RUN;
          sel_valid_d = 1'b1;
          busy_d      = 1'b1;
          step_d      = 1'b1;
        end
      end

      ST_RUN: begin
        if (bus.stop) begin
          // stop wins over a coinciding advance: sel keeps its last value
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          sel_valid_d = 1'b1;
          busy_d      = 1'b1;
          if (dwell_expired) begin
            cnt_d = '0;
            if (mode_l_q == MODE_ONESHOT && sel_q == 3'd7) begin
              state_d     = ST_DONE;
              done_d      = 1'b1;
              sel_valid_d = 1'b0;
              busy_d      = 1'b0;
            end else begin
              sel_d    = sel_adv;
              dir_up_d = dir_adv;
              step_d   = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + DWELL_ONE;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      mode_l_q    <= MODE_UP;
      dwell_l_q   <= DWELL_ONE;
      cnt_q       <= '0;
      dir_up_q    <= 1'b1;
      sel_q       <= 3'd0;
      sel_valid_q <= 1'b0;
      step_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_l_q    <= mode_l_d;
      dwell_l_q   <= dwell_l_d;
      cnt_q       <= cnt_d;
      dir_up_q    <= dir_up_d;
      sel_q       <= sel_d;
      sel_valid_q <= sel_valid_d;
      step_q      <= step_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // sel[2] drives decoder input a, sel[1] b, sel[0] c
  assign bus.sel       = sel_q;
  assign bus.sel_valid = sel_valid_q;
  assign bus.step      = step_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Directed bench for decoder_scan_ctrl: each stimulus cycle pushes the expected
// registered outputs to a scoreboard that a negedge checker drains.
module tb_decoder_scan_ctrl;

  logic clk;
  logic rst;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  typedef struct {
    int         due;
    logic [6:0] exp;
    string      tag;
  } sb_item_t;

  sb_item_t   sb[$];
  sb_item_t   cur;
  logic [6:0] obs;
  logic [2:0] pp [16];

  decoder_scan_ctrl_if #(.DWELL_W(8)) bus ();

  decoder_scan_ctrl #(.DWELL_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard checker: compares on the falling edge, away from the active edge
  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].due < cyc) begin
      cur = sb.pop_front();
      checks++;
      errors++;
      $display("FAIL %s: expectation for cycle %0d never compared (now %0d)", cur.tag, cur.due, cyc);
    end else if (sb.size() > 0 && sb[0].due == cyc) begin
      cur = sb.pop_front();
      obs = {bus.sel, bus.sel_valid, bus.step, bus.busy, bus.done};
      checks++;
      assert (obs === cur.exp) else begin
        errors++;
        $error("FAIL %s @cyc %0d: got sel=%0d valid=%b step=%b busy=%b done=%b, want sel=%0d valid=%b step=%b busy=%b done=%b",
               cur.tag, cyc, obs[6:4], obs[3], obs[2], obs[1], obs[0],
               cur.exp[6:4], cur.exp[3], cur.exp[2], cur.exp[1], cur.exp[0]);
      end
      $display("check %s @cyc %0d sel=%0d valid=%b step=%b busy=%b done=%b",
               cur.tag, cyc, obs[6:4], obs[3], obs[2], obs[1], obs[0]);
    end
  end

  // One clock of stimulus; the expectation is for the outputs after the next edge.
  task automatic drive(input logic r, input logic s, input logic p,
                       input logic [1:0] m, input logic [7:0] d,
                       input logic [2:0] e_sel, input logic e_v, input logic e_step,
                       input logic e_busy, input logic e_done, input string tag);
    sb_item_t it;
    @(posedge clk);
    #1;
    rst       = r;
    bus.start = s;
    bus.stop  = p;
    bus.mode  = m;
    bus.dwell = d;
    it.due = cyc + 1;
    it.exp = {e_sel, e_v, e_step, e_busy, e_done};
    it.tag = tag;
    sb.push_back(it);
  endtask

  initial begin
    pp = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7,
           3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd1};
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    bus.mode  = 2'b00;
    bus.dwell = 8'd0;

    // Reset then idle
    drive(1, 0, 0, 2'd0, 8'd0, 3'd0, 0, 0, 0, 0, "reset0");
    drive(1, 0, 0, 2'd0, 8'd0, 3'd0, 0, 0, 0, 0, "reset1");
    drive(0, 0, 0, 2'd0, 8'd0, 3'd0, 0, 0, 0, 0, "idle0");
    drive(0, 0, 0, 2'd0, 8'd0, 3'd0, 0, 0, 0, 0, "idle1");
    drive(0, 1, 1, 2'd0, 8'd3, 3'd0, 0, 0, 0, 0, "start_and_stop_idle");

    // UP, dwell 3, mode/dwell inputs disturbed during the run
    drive(0, 1, 0, 2'd0, 8'd3, 3'd0, 1, 1, 1, 0, "up_start");
    for (int i = 1; i < 27; i++)
      drive(0, 0, 0, 2'd3, 8'd7, 3'((i / 3) % 8), 1, (i % 3) == 0, 1, 0, "up_run");
    drive(0, 0, 1, 2'd0, 8'd0, 3'd0, 0, 0, 0, 0, "up_stop");
    drive(0, 0, 0, 2'd0, 8'd0, 3'd0, 0, 0, 0, 0, "up_idle");

    // DOWN, dwell 0 treated as 1
    drive(0, 1, 0, 2'd1, 8'd0, 3'd7, 1, 1, 1, 0, "down_start");
    for (int i = 1; i < 10; i++)
      drive(0, 0, 0, 2'd1, 8'd0, 3'(7 - i), 1, 1, 1, 0, "down_run");
    drive(0, 0, 1, 2'd1, 8'd0, 3'd6, 0, 0, 0, 0, "down_stop");

    // PINGPONG, dwell 1
    drive(0, 1, 0, 2'd2, 8'd1, pp[0], 1, 1, 1, 0, "pp_start");
    for (int i = 1; i < 16; i++)
      drive(0, 0, 0, 2'd2, 8'd1, pp[i], 1, 1, 1, 0, "pp_run");
    drive(0, 0, 1, 2'd2, 8'd1, 3'd1, 0, 0, 0, 0, "pp_stop");

    // ONESHOT, dwell 2, start held across DONE -> IDLE
    drive(0, 1, 0, 2'd3, 8'd2, 3'd0, 1, 1, 1, 0, "os_start");
    for (int i = 1; i < 16; i++)
      drive(0, 0, 0, 2'd3, 8'd2, 3'(i / 2), 1, (i % 2) == 0, 1, 0, "os_run");
    drive(0, 1, 0, 2'd3, 8'd2, 3'd7, 0, 0, 0, 1, "os_done");
    drive(0, 1, 0, 2'd3, 8'd2, 3'd7, 0, 0, 0, 0, "os_idle");
    drive(0, 1, 0, 2'd3, 8'd2, 3'd0, 1, 1, 1, 0, "os_restart");
    drive(0, 0, 0, 2'd3, 8'd2, 3'd0, 1, 0, 1, 0, "os_restart_hold");
    drive(0, 0, 1, 2'd3, 8'd2, 3'd0, 0, 0, 0, 0, "os_stop");

    // Stop on the last dwell cycle of sel=2 beats the advance
    drive(0, 1, 0, 2'd0, 8'd4, 3'd0, 1, 1, 1, 0, "sva_start");
    for (int i = 1; i < 12; i++)
      drive(0, 0, 0, 2'd0, 8'd4, 3'(i / 4), 1, (i % 4) == 0, 1, 0, "sva_run");
    drive(0, 0, 1, 2'd0, 8'd4, 3'd2, 0, 0, 0, 0, "sva_stop");
    drive(0, 0, 0, 2'd0, 8'd4, 3'd2, 0, 0, 0, 0, "sva_idle");

    // Reset mid-scan at sel=5, with start also high
    drive(0, 1, 0, 2'd0, 8'd4, 3'd0, 1, 1, 1, 0, "rst_start");
    for (int i = 1; i < 21; i++)
      drive(0, 0, 0, 2'd0, 8'd4, 3'(i / 4), 1, (i % 4) == 0, 1, 0, "rst_run");
    drive(1, 1, 0, 2'd0, 8'd4, 3'd0, 0, 0, 0, 0, "rst_mid_scan");
    drive(0, 0, 0, 2'd0, 8'd4, 3'd0, 0, 0, 0, 0, "rst_idle");

    // Maximum dwell held exactly
    drive(0, 1, 0, 2'd0, 8'd255, 3'd0, 1, 1, 1, 0, "max_start");
    for (int i = 1; i < 257; i++)
      drive(0, 0, 0, 2'd0, 8'd255, 3'(i / 255), 1, (i % 255) == 0, 1, 0, "max_run");
    drive(0, 0, 1, 2'd0, 8'd255, 3'd1, 0, 0, 0, 0, "max_stop");

    repeat (3) @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/decoder_scan_ctrl.md
Name: decoder_scan_ctrl

Overview:
- Sequential select generator directly upstream of the 3x8 decoder.
- Produces the 3-bit index {a,b,c} that the decoder turns into a one-hot line.
- Steps the index through 0..7 under a programmable dwell time, in one of four scan modes.
- Provides start/stop control and status flags to the surrounding logic.

Parameters:
- DWELL_W, 8: width of the dwell-count input and the internal dwell counter.

Ports:
- clk    input   1        single system clock; all logic on rising edge
- rst    input   1        synchronous, active-high reset
- start  input   1        level-sampled; begins a scan when in IDLE
- stop   input   1        level-sampled; aborts a scan, returns to IDLE
- mode   input   2        00 UP, 01 DOWN, 10 PINGPONG, 11 ONESHOT; sampled at start only
- dwell  input   DWELL_W  cycles each index is held; 0 treated as 1; sampled at start only
- sel    output  3        index to the decoder; sel[2] drives a, sel[1] b, sel[0] c
- sel_valid output 1      1 while sel is a live scan value (RUN state)
- step   output  1        one-cycle pulse coincident with every new sel value, including the first
- busy   output  1        1 in RUN
- done   output  1        one-cycle pulse at ONESHOT completion

Behaviour:
- All outputs are registered. Clock is clk; reset is synchronous, active-high on rst.
- Reset values: sel=0, sel_valid=0, step=0, busy=0, done=0, state=IDLE, dwell counter=0, ping-pong direction=up.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 and stop=0 → latch mode and dwell (dwell_l = dwell, or 1 if dwell==0).
  - Load sel=7 for DOWN, sel=0 otherwise. Clear the counter and set direction=up.
  - Go to RUN. On the cycle after start is sampled: sel_valid=1, busy=1, step=1.
- RUN:
  - The counter increments every cycle. When counter==dwell_l-1, clear it and advance sel; step=1 on the cycle the new sel appears, 0 otherwise.
  - Each sel value is therefore held exactly dwell_l cycles.
  - UP: sel+1, 7 wraps to 0.
  - DOWN: sel-1, 0 wraps to 7.
  - PINGPONG: sequence 0,1,..,7,6,..,1,0,1,... Direction flips on reaching 7 (going down) and on reaching 0 (going up). Endpoints are held one dwell period, not two.
  - ONESHOT: 0..7 ascending. When the dwell at 7 expires, go to DONE; sel stays 7 and no step is issued.
- DONE:
  - Lasts exactly one cycle: done=1, sel_valid=0, busy=0, step=0. Then go to IDLE.
- Stop and start handling:
  - stop=1 in RUN → next cycle is IDLE with sel_valid=0, busy=0, step=0. sel holds its last value and the counter clears.
  - stop has priority over a coinciding advance: sel does not change.
  - start and stop both 1 in IDLE → stay IDLE.
  - start while in RUN or DONE is ignored. A start held high across DONE→IDLE restarts a scan on the following cycle.
  - Changes to mode or dwell during RUN have no effect until the next start.
- Reset asserted mid-scan: on the next edge all outputs return to their reset values regardless of state. rst has priority over start and stop.
- Counter width is DWELL_W. The maximum dwell (2^DWELL_W - 1) must be held exactly with no counter overflow.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, start=0 → sel=0, sel_valid=0, busy=0, step=0, done=0 on every cycle.
- UP with dwell=3: start pulse → sel sequence 0,0,0,1,1,1,...,7,7,7,0; step=1 on the first cycle of each value; wraps 7→0 continuously.
- DOWN with dwell=0: dwell treated as 1 → sel 7,6,5,...,0,7 on consecutive cycles; step=1 every cycle.
- PINGPONG with dwell=1 → sel 0,1,2,3,4,5,6,7,6,5,4,3,2,1,0,1; no repeated endpoints.
- ONESHOT with dwell=2 → sel 0,0,1,1,...,7,7; then one cycle with done=1, sel_valid=0, sel=7; then IDLE. A new start is accepted afterwards.
- Stop vs. advance, and mid-scan reset:
  - UP with dwell=4; assert stop on the last dwell cycle of sel=2 → sel stays 2, sel_valid=0 next cycle, no step.
  - Repeat the scan and assert rst at sel=5 → all outputs reach reset values one cycle later.
